bdd_tree_loader: RTL

- Upstream configuration stage of the BDD accelerator.
- Accepts a byte-serial tree image over a valid/ready stream and assembles 34-bit node words (threshold/weight store) and 18-bit branch words (two 9-bit {leaf flag, target/class} fields).
- Drives the write ports of the two node SRAMs: we1, we2, shared address, and the two data buses.
- Holds each write strobe long enough for the divided-clock SRAMs (clk/4 and clk/2) to capture it.

---
 rtl/bdd_tree_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bdd_tree_loader.sv
// Byte-serial tree image loader: assembles node/branch words and drives both SRAM write ports.
// Latency: a word's strobe starts the cycle after its last byte; we1 is held WE1_HOLD cycles and we2 WE2_HOLD cycles.
// Backpressure: s_ready is low in IDLE, DONE and both write-hold states; stream holes simply stall the FSM.
module bdd_tree_loader #(
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 18,
  parameter int ADDR_WIDTH      = 5,
  parameter int DEPTH           = 32,
  parameter int WE1_HOLD        = 4,
  parameter int WE2_HOLD        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       we1,
  output logic                       we2,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_err
);

  typedef enum logic [2:0] {IDLE, HDR, R1B, R1W, R2B, R2W, DONE, DRAIN} state_t;

  localparam logic [2:0] H1_LAST = 3'(WE1_HOLD - 1);
  localparam logic [2:0] H2_LAST = 3'(WE2_HOLD - 1);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t                state;
  logic [2:0]            byte_cnt;
  logic [2:0]            hold_cnt;
  logic [ADDR_WIDTH-1:0] node_cnt;
  logic [ADDR_WIDTH-1:0] n_last;    // index of the final node (N-1)
  logic                  last_seen; // s_last flag of the most recent branch word's final byte
  logic                  accept;

  // Stream and strobe outputs decode straight from the state register, so reset clears them at once.
  assign s_ready = (state == HDR) || (state == R1B) || (state == R2B) || (state == DRAIN);
  assign we1     = (state == R1W);
  assign we2     = (state == R2W);
  assign busy    = (state != IDLE) && (state != DONE);
  assign wr_addr = node_cnt;
  assign accept  = s_valid && s_ready;

  // Load sequencer: header check, byte assembly, write holds, completion and error handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      hold_cnt  <= '0;
      node_cnt  <= '0;
      n_last    <= '0;
      last_seen <= 1'b0;
      ram1_data <= '0;
      ram2_data <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            node_cnt  <= '0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            byte_cnt <= '0;
            if (s_data == 8'd0 || s_data > DEPTH_B) begin
              load_err <= 1'b1;
              state    <= s_last ? IDLE : DRAIN;
            end else if (s_last) begin
              // A lone valid header is a truncated image.
              load_err <= 1'b1;
              state    <= IDLE;
            end else begin
              n_last <= ADDR_WIDTH'(s_data - 8'd1);
              state  <= R1B;
            end
          end
        end
        R1B: begin
          if (accept) begin
            // Bits above the word width of the first byte fall off the top of the shift.
            ram1_data <= {ram1_data[RAM1_DATA_WIDTH-9:0], s_data};
            if (s_last) begin
              load_err <= 1'b1;
              state    <= IDLE;
            end else if (byte_cnt == 3'd4) begin
              byte_cnt <= '0;
              hold_cnt <= '0;
              state    <= R1W;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        R1W: begin
          if (hold_cnt == H1_LAST) begin
            byte_cnt <= '0;
            state    <= R2B;
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        R2B: begin
          if (accept) begin
            ram2_data <= {ram2_data[RAM2_DATA_WIDTH-9:0], s_data};
            if (byte_cnt == 3'd2) begin
              if (s_last && node_cnt != n_last) begin
                load_err <= 1'b1;
                state    <= IDLE;
              end else begin
                last_seen <= s_last;
                hold_cnt  <= '0;
                state     <= R2W;
              end
            end else if (s_last) begin
              load_err <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        R2W: begin
          if (hold_cnt == H2_LAST) begin
            if (node_cnt == n_last) begin
              if (last_seen) begin
                load_done <= 1'b1;
                state     <= DONE;
              end else begin
                load_err <= 1'b1;
                state    <= DRAIN;
              end
            end else begin
              node_cnt <= node_cnt + 1'b1;
              byte_cnt <= '0;
              state    <= R1B;
            end
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (accept && s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
